data_mem_port: RTL

Load/store access sequencer between the EX-stage memory control signals and a byte-wide synchronous data memory. It splits 16-bit halfword accesses into byte cycles and assembles or sign/zero-extends load data. It returns the result as `ReadData`, the memory-side source of the write-back select feeding the register file. It runs a handshake so the pipeline stalls on `Busy` and resumes on `Done`.

---
 rtl/data_mem_port_if.sv | 51 +++++
 rtl/data_mem_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_port_if.sv
// ---------------------------------------------------------------------------
// data_mem_port_if
//
// Bundles the pipeline-side request/response signals and the byte-wide
// memory-side signals of data_mem_port.
//
// Ports (signals):
//   Start, MemRead, MemWrite, MemHalf, MemUnsigned  request strobe and kind
//   Address, StoreData                              request address/data
//   ReadData, Busy, Done, AlignErr                  response to the pipeline
//   MemAddr, MemRE, MemWE, MemWData                 memory command
//   MemRData                                        memory read byte
//
// Modports:
//   slave  : the access sequencer itself
//   master : its environment (pipeline plus the data memory)
// ---------------------------------------------------------------------------
interface data_mem_port_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  Start;
   logic                  MemRead;
   logic                  MemWrite;
   logic                  MemHalf;
   logic                  MemUnsigned;
   logic [ADDR_WIDTH-1:0] Address;
   logic [ADDR_WIDTH-1:0] StoreData;
   logic [ADDR_WIDTH-1:0] ReadData;
   logic                  Busy;
   logic                  Done;
   logic                  AlignErr;
   logic [ADDR_WIDTH-1:0] MemAddr;
   logic                  MemRE;
   logic                  MemWE;
   logic [7:0]            MemWData;
   logic [7:0]            MemRData;

   modport slave (
      input  Start, MemRead, MemWrite, MemHalf, MemUnsigned, Address, StoreData,
      input  MemRData,
      output ReadData, Busy, Done, AlignErr,
      output MemAddr, MemRE, MemWE, MemWData
   );

   modport master (
      output Start, MemRead, MemWrite, MemHalf, MemUnsigned, Address, StoreData,
      output MemRData,
      input  ReadData, Busy, Done, AlignErr,
      input  MemAddr, MemRE, MemWE, MemWData
   );
endinterface

// File: rtl/data_mem_port.sv
// ---------------------------------------------------------------------------
// data_mem_port
//
// Load/store access sequencer between the EX-stage memory controls and a
// byte-wide synchronous data memory. Halfword accesses are split into two
// little-endian byte cycles (A, then A+1 with wrap); byte loads are sign- or
// zero-extended. The pipeline stalls on Busy and resumes on the Done pulse.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_mem_port_if.slave (request, response and memory signals)
//
// Optional feature macro: ALIGN_TRAP_EN
//   defined   : odd-address halfwords skip the memory and pulse AlignErr
//   undefined : odd-address halfwords run normally, AlignErr tied to 0
//
// Halfword data assembly assumes ADDR_WIDTH >= 16.
// ---------------------------------------------------------------------------
module data_mem_port #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_port_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, FINISH} state_t;

   state_t                state, state_next;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            data_hi_q;
   logic                  load_q, store_q, half_q, unsigned_q;
   logic [7:0]            byte0_q;

   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_next;
   logic                  mem_re_q, mem_re_next;
   logic                  mem_we_q, mem_we_next;
   logic [7:0]            mem_wdata_q, mem_wdata_next;
   logic [ADDR_WIDTH-1:0] read_data_q;
   logic                  done_q;

   logic                  accept, req_load, req_store, req_trap, finish_load;
   logic [15:0]           load_word;

   // A load takes priority when both MemRead and MemWrite are raised.
   assign req_load  = bus.MemRead;
   assign req_store = bus.MemWrite & ~bus.MemRead;
   assign accept    = (state == IDLE) && bus.Start && (bus.MemRead || bus.MemWrite);

`ifdef ALIGN_TRAP_EN
   logic trap_q;
   logic align_err_q;

   assign req_trap    = bus.MemHalf & bus.Address[0];
   assign finish_load = load_q & ~trap_q;
`else
   assign req_trap    = 1'b0;
   assign finish_load = load_q;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state plus the next memory command. The command is registered so
   // the memory sees it in the cycle the FSM spends in ISSUE0/ISSUE1.
   always_comb begin
      state_next     = state;
      mem_addr_next  = mem_addr_q;
      mem_re_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_wdata_next = mem_wdata_q;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_trap) begin
                  state_next = FINISH;
               end else begin
                  state_next     = ISSUE0;
                  mem_addr_next  = bus.Address;
                  mem_re_next    = req_load;
                  mem_we_next    = req_store;
                  mem_wdata_next = bus.StoreData[7:0];
               end
            end
         end
         ISSUE0: begin
            if (half_q) begin
               state_next     = ISSUE1;
               mem_addr_next  = addr_q + ADDR_WIDTH'(1);
               mem_re_next    = load_q;
               mem_we_next    = store_q;
               mem_wdata_next = data_hi_q;
            end else begin
               state_next = FINISH;
            end
         end
         ISSUE1:  state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Final load value, formed in FINISH while the last read byte is on MemRData.
   always_comb begin
      if (half_q)          load_word = {bus.MemRData, byte0_q};
      else if (unsigned_q) load_word = {8'h00, bus.MemRData};
      else                 load_word = {{8{bus.MemRData[7]}}, bus.MemRData};
   end

   // Request latch, memory command register, low-byte capture and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         data_hi_q   <= '0;
         load_q      <= 1'b0;
         store_q     <= 1'b0;
         half_q      <= 1'b0;
         unsigned_q  <= 1'b0;
         byte0_q     <= '0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         read_data_q <= '0;
         done_q      <= 1'b0;
      end else begin
         if (accept) begin
            addr_q     <= bus.Address;
            data_hi_q  <= bus.StoreData[15:8];
            load_q     <= req_load;
            store_q    <= req_store;
            half_q     <= bus.MemHalf;
            unsigned_q <= bus.MemUnsigned;
         end
         if (state == ISSUE1) byte0_q <= bus.MemRData;
         mem_addr_q  <= mem_addr_next;
         mem_re_q    <= mem_re_next;
         mem_we_q    <= mem_we_next;
         mem_wdata_q <= mem_wdata_next;
         if (state == FINISH && finish_load) read_data_q <= ADDR_WIDTH'(load_word);
         done_q <= (state == FINISH);
      end
   end

`ifdef ALIGN_TRAP_EN
   // Trap flag for the current access and the AlignErr pulse aligned with Done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q      <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         if (accept) trap_q <= req_trap;
         align_err_q <= (state == FINISH) && trap_q;
      end
   end

   assign bus.AlignErr = align_err_q;
`else
   assign bus.AlignErr = 1'b0;
`endif

   assign bus.Busy     = (state != IDLE);
   assign bus.Done     = done_q;
   assign bus.ReadData = read_data_q;
   assign bus.MemAddr  = mem_addr_q;
   assign bus.MemRE    = mem_re_q;
   assign bus.MemWE    = mem_we_q;
   assign bus.MemWData = mem_wdata_q;

endmodule
